// File: rtl/cpu_bus_mem.sv
// cpu_bus_mem
// Memory responder for a 6502-style CPU bus. It serves CPU reads and writes
// from a mirrored backing store and can insert a fixed number of wait
// states, during which rdy is held low. Writes to an optional upper
// read-only region are dropped and flagged. A separate preload port can
// fill the store while the bus is idle.
//
// Ports:
//   clk          - system clock, all state changes on the rising edge
//   rst          - synchronous active-high reset
//   ren, wen     - CPU read / write request
//   cpu_addr_out - CPU address (ADDR_W bits)
//   cpu_data_out - CPU write data (DATA_W bits)
//   cpu_data_in  - registered read data returned to the CPU
//   rdy          - high when the slave is idle / the access is completing
//   ld_en        - preload write strobe
//   ld_addr      - preload physical address (MEM_AW bits)
//   ld_data      - preload data
//   wr_err       - one-cycle pulse: protected write dropped, or ren&wen together

module cpu_bus_mem #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 8,
    parameter int                MEM_AW      = 11,
    parameter int                WAIT_STATES = 0,
    parameter logic [ADDR_W-1:0] RO_BASE     = 'hE000,
    parameter bit                RO_EN       = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ren,
    input  logic              wen,
    input  logic [ADDR_W-1:0] cpu_addr_out,
    input  logic [DATA_W-1:0] cpu_data_out,
    output logic [DATA_W-1:0] cpu_data_in,
    output logic              rdy,
    input  logic              ld_en,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              wr_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    logic [DATA_W-1:0] mem [0:(2**MEM_AW)-1];

    logic [0:0]        state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic              cap_we;
    logic              cap_both;

    logic              req;
    logic              acc_fire;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              acc_we;
    logic              acc_both;
    logic [MEM_AW-1:0] acc_idx;
    logic              acc_prot;
    logic              cpu_we;
    logic              ld_ok;

    assign req = ren | wen;
    assign rdy = (state == S_IDLE);

    // Select the access that completes at this edge. With no wait states the
    // live bus inputs complete immediately; otherwise the captured request
    // completes on the last wait cycle.
    always_comb begin
        acc_fire = 1'b0;
        acc_addr = cap_addr;
        acc_data = cap_data;
        acc_we   = cap_we;
        acc_both = cap_both;
        if (WAIT_STATES == 0) begin
            acc_fire = (state == S_IDLE) && req;
            acc_addr = cpu_addr_out;
            acc_data = cpu_data_out;
            acc_we   = wen;
            acc_both = ren & wen;
        end else begin
            acc_fire = (state == S_WAIT) && (wait_cnt == 4'd1);
        end
    end

    // Upper address bits are simply dropped, so the store mirrors across the
    // whole CPU space. Protection compares the full, unmirrored address.
    assign acc_idx  = acc_addr[MEM_AW-1:0];
    assign acc_prot = RO_EN && (acc_addr >= RO_BASE);

    // Reset suppresses every store write, which is what aborts a write that
    // was still pending in WAIT. Preload only gets the array when the CPU
    // is not using it this edge.
    assign cpu_we = !rst && acc_fire && acc_we && !acc_prot;
    assign ld_ok  = !rst && ld_en && (state == S_IDLE) && !req;

    // Backing store; contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (cpu_we) begin
            mem[acc_idx] <= acc_data;
        end else if (ld_ok) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Bus FSM, read data register and error pulse. A request with ren and
    // wen both high is a write; the error flag for it and for a protected
    // write are OR'ed so one access never produces more than one pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            cpu_data_in <= '0;
            wr_err      <= 1'b0;
            cap_addr    <= '0;
            cap_data    <= '0;
            cap_we      <= 1'b0;
            cap_both    <= 1'b0;
        end else begin
            wr_err <= acc_fire && acc_we && (acc_prot || acc_both);
            if (acc_fire && !acc_we) begin
                cpu_data_in <= mem[acc_idx];
            end
            case (state)
                S_IDLE: begin
                    if (req && (WAIT_STATES != 0)) begin
                        cap_addr <= cpu_addr_out;
                        cap_data <= cpu_data_out;
                        cap_we   <= wen;
                        cap_both <= ren & wen;
                        wait_cnt <= WS_INIT;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        wait_cnt <= 4'd0;
                        state    <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    wait_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule
